// File: rtl/dfi_data_timing.sv
// dfi_data_timing
//   DFI data-path timing engine. Accepted READ/WRITE commands are turned into
//   per-phase dfi_wrdata_en / dfi_rddata_en windows at a programmable latency.
//   Write bursts are buffered and sliced onto the per-phase write lanes.
//   Read bursts are tracked against the returned dfi_rddata_valid beats.
//
// Ports
//   clk, rst                       controller clock, sync active-high reset
//   cmd_valid/ready/write/phase    command handshake and phase slot
//   cfg_tphy_wrlat, cfg_trddata_en latencies in phases, sampled at accept
//   wr_data, wr_mask, wr_ready     burst write data taken with the command
//   dfi_wrdata_en/wrdata/mask      per-phase write lanes (lane q = phase q)
//   dfi_rddata_en                  per-phase read enable
//   dfi_rddata, dfi_rddata_valid   PHY read return
//   rd_data, rd_data_valid         read return delayed one cycle
//   rd_outstanding                 read bursts in flight
//   err_rd_unexpected              sticky: valid beat with nothing expected
module dfi_data_timing #(
   parameter int C_PHASES         = 2,
   parameter int C_DATA_WIDTH     = 128,
   parameter int C_BURST_PHASES   = 4,
   parameter int C_LAT_WIDTH      = 5,
   parameter int C_WR_DEPTH       = 4,
   parameter int C_RD_OUTSTANDING = 8
) (
   input  logic                                          clk,
   input  logic                                          rst,
   input  logic                                          cmd_valid,
   output logic                                          cmd_ready,
   input  logic                                          cmd_write,
   input  logic [((C_PHASES > 1) ? $clog2(C_PHASES) : 1)-1:0] cmd_phase,
   input  logic [C_LAT_WIDTH-1:0]                        cfg_tphy_wrlat,
   input  logic [C_LAT_WIDTH-1:0]                        cfg_trddata_en,
   input  logic [C_BURST_PHASES*C_DATA_WIDTH-1:0]        wr_data,
   input  logic [C_BURST_PHASES*C_DATA_WIDTH/8-1:0]      wr_mask,
   output logic                                          wr_ready,
   output logic [C_PHASES-1:0]                           dfi_wrdata_en,
   output logic [C_PHASES*C_DATA_WIDTH-1:0]              dfi_wrdata,
   output logic [C_PHASES*C_DATA_WIDTH/8-1:0]            dfi_wrdata_mask,
   output logic [C_PHASES-1:0]                           dfi_rddata_en,
   input  logic [C_PHASES*C_DATA_WIDTH-1:0]              dfi_rddata,
   input  logic [C_PHASES-1:0]                           dfi_rddata_valid,
   output logic [C_PHASES*C_DATA_WIDTH-1:0]              rd_data,
   output logic [C_PHASES-1:0]                           rd_data_valid,
   output logic [$clog2(C_RD_OUTSTANDING):0]             rd_outstanding,
   output logic                                          err_rd_unexpected
);
   localparam int MW = C_DATA_WIDTH / 8;
   // Schedule horizon in phases: max latency + burst + phase slot.
   localparam int H  = (1 << C_LAT_WIDTH) + C_BURST_PHASES + C_PHASES;
   localparam int BW = (C_BURST_PHASES > 1) ? $clog2(C_BURST_PHASES) : 1;
   localparam int SW = (C_WR_DEPTH > 1) ? $clog2(C_WR_DEPTH) : 1;
   localparam int RW = $clog2(C_RD_OUTSTANDING) + 1;

   // Phase schedule: entry i is the phase i places after the first phase of
   // the next cycle. Entries 0..C_PHASES-1 are loaded into the output
   // registers at the coming edge, then the whole schedule shifts down.
   logic [H-1:0]          wsch_en, rsch_en, wn_en, rn_en;
   logic [H-1:0][BW-1:0]  wsch_beat, wn_beat;
   logic [H-1:0][SW-1:0]  wsch_slot, wn_slot;

   logic [C_WR_DEPTH-1:0]                                      slot_vld;
   logic [C_WR_DEPTH-1:0][C_BURST_PHASES-1:0][C_DATA_WIDTH-1:0] buf_data;
   logic [C_WR_DEPTH-1:0][C_BURST_PHASES-1:0][MW-1:0]          buf_mask;
   logic [C_BURST_PHASES-1:0][C_DATA_WIDTH-1:0] wr_beats;
   logic [C_BURST_PHASES-1:0][MW-1:0]           wr_mbeats;
   logic          last_vld_q;
   logic [SW-1:0] last_slot_q;
   logic [BW-1:0] beat_cnt;

   int            wr_off, rd_off, phase_i;
   logic          wr_ovl, rd_ovl, have_free, acc_wr, acc_rd;
   logic [SW-1:0] alloc;

   logic [C_PHASES-1:0][C_DATA_WIDTH-1:0] lane_data;
   logic [C_PHASES-1:0][MW-1:0]           lane_mask;
   logic          last_hit;
   logic [SW-1:0] last_slot;

   int            pop, sum;
   logic          unexp, wrap;
   logic [BW-1:0] beat_nxt;
   logic [RW-1:0] rd_out_nxt;

   assign wr_beats  = wr_data;
   assign wr_mbeats = wr_mask;
   assign wr_ready  = cmd_valid & cmd_write & cmd_ready;

   // Admission and schedule insertion.
   always_comb begin
      phase_i   = (C_PHASES > 1) ? int'(cmd_phase) : 0;
      wr_off    = phase_i + int'(cfg_tphy_wrlat);
      rd_off    = phase_i + int'(cfg_trddata_en);
      wr_ovl    = 1'b0;
      rd_ovl    = 1'b0;
      for (int k = 0; k < C_BURST_PHASES; k++) begin
         if (wsch_en[wr_off + k]) wr_ovl = 1'b1;
         if (rsch_en[rd_off + k]) rd_ovl = 1'b1;
      end
      have_free = 1'b0;
      alloc     = '0;
      for (int s = C_WR_DEPTH - 1; s >= 0; s--) begin
         if (!slot_vld[s]) begin
            have_free = 1'b1;
            alloc     = SW'(s);
         end
      end
      if (cmd_write) cmd_ready = !wr_ovl && have_free;
      else           cmd_ready = !rd_ovl && (rd_outstanding < RW'(C_RD_OUTSTANDING));
      acc_wr = cmd_valid & cmd_ready & cmd_write;
      acc_rd = cmd_valid & cmd_ready & ~cmd_write;

      wn_en   = wsch_en;
      wn_beat = wsch_beat;
      wn_slot = wsch_slot;
      rn_en   = rsch_en;
      if (acc_wr) begin
         for (int k = 0; k < C_BURST_PHASES; k++) begin
            wn_en[wr_off + k]   = 1'b1;
            wn_beat[wr_off + k] = BW'(k);
            wn_slot[wr_off + k] = alloc;
         end
      end
      if (acc_rd) begin
         for (int k = 0; k < C_BURST_PHASES; k++) rn_en[rd_off + k] = 1'b1;
      end
   end

   // Lane data for the next cycle. A zero-latency write lands on the next
   // edge before its buffer slot is written, so bypass from wr_data.
   always_comb begin
      lane_data = '0;
      lane_mask = '0;
      last_hit  = 1'b0;
      last_slot = '0;
      for (int q = 0; q < C_PHASES; q++) begin
         if (wn_en[q]) begin
            if (acc_wr && wn_slot[q] == alloc) begin
               lane_data[q] = wr_beats[wn_beat[q]];
               lane_mask[q] = wr_mbeats[wn_beat[q]];
            end else begin
               lane_data[q] = buf_data[wn_slot[q]][wn_beat[q]];
               lane_mask[q] = buf_mask[wn_slot[q]][wn_beat[q]];
            end
            if (wn_beat[q] == BW'(C_BURST_PHASES - 1)) begin
               last_hit  = 1'b1;
               last_slot = wn_slot[q];
            end
         end
      end
   end

   // Read beat accounting; beats with nothing expected are not counted.
   always_comb begin
      pop = 0;
      for (int q = 0; q < C_PHASES; q++) pop += int'(dfi_rddata_valid[q]);
      unexp      = (pop != 0) && (rd_outstanding == '0) && (beat_cnt == '0);
      sum        = int'(beat_cnt) + (unexp ? 0 : pop);
      wrap       = (sum >= C_BURST_PHASES);
      beat_nxt   = BW'(wrap ? sum - C_BURST_PHASES : sum);
      rd_out_nxt = rd_outstanding;
      if (acc_rd && !(wrap && rd_outstanding != '0))
         rd_out_nxt = rd_outstanding + RW'(1);
      else if (!acc_rd && wrap && rd_outstanding != '0)
         rd_out_nxt = rd_outstanding - RW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wsch_en           <= '0;
         wsch_beat         <= '0;
         wsch_slot         <= '0;
         rsch_en           <= '0;
         slot_vld          <= '0;
         last_vld_q        <= 1'b0;
         last_slot_q       <= '0;
         dfi_wrdata_en     <= '0;
         dfi_wrdata        <= '0;
         dfi_wrdata_mask   <= '0;
         dfi_rddata_en     <= '0;
         rd_data           <= '0;
         rd_data_valid     <= '0;
         rd_outstanding    <= '0;
         beat_cnt          <= '0;
         err_rd_unexpected <= 1'b0;
      end else begin
         for (int i = 0; i < H; i++) begin
            if (i + C_PHASES < H) begin
               wsch_en[i]   <= wn_en[i + C_PHASES];
               wsch_beat[i] <= wn_beat[i + C_PHASES];
               wsch_slot[i] <= wn_slot[i + C_PHASES];
               rsch_en[i]   <= rn_en[i + C_PHASES];
            end else begin
               wsch_en[i]   <= 1'b0;
               wsch_beat[i] <= '0;
               wsch_slot[i] <= '0;
               rsch_en[i]   <= 1'b0;
            end
         end
         dfi_wrdata_en   <= wn_en[C_PHASES-1:0];
         dfi_wrdata      <= lane_data;
         dfi_wrdata_mask <= lane_mask;
         dfi_rddata_en   <= rn_en[C_PHASES-1:0];
         // Slot frees the cycle after its last beat is on the bus.
         last_vld_q  <= last_hit;
         last_slot_q <= last_slot;
         if (last_vld_q) slot_vld[last_slot_q] <= 1'b0;
         if (acc_wr)     slot_vld[alloc]       <= 1'b1;
         rd_data        <= dfi_rddata;
         rd_data_valid  <= dfi_rddata_valid;
         rd_outstanding <= rd_out_nxt;
         beat_cnt       <= beat_nxt;
         if (unexp) err_rd_unexpected <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (acc_wr) begin
         buf_data[alloc] <= wr_beats;
         buf_mask[alloc] <= wr_mbeats;
      end
   end
endmodule

// File: tb/tb_dfi_data_timing.sv
// tb_dfi_data_timing
//   Randomized bench for dfi_data_timing. The reference model keeps accepted
//   bursts as absolute-phase windows and derives every expected output from
//   the window arithmetic each cycle.
module tb_dfi_data_timing;
   localparam int CP = 2, DW = 128, BP = 4, LW = 5, WD = 4, RO = 8;
   localparam int MW = DW / 8;
   localparam int NCYC = 3000;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  cmd_valid, cmd_ready, cmd_write, wr_ready;
   logic [0:0]            cmd_phase;
   logic [LW-1:0]         cfg_tphy_wrlat, cfg_trddata_en;
   logic [BP*DW-1:0]      wr_data;
   logic [BP*MW-1:0]      wr_mask;
   logic [CP-1:0]         dfi_wrdata_en, dfi_rddata_en, dfi_rddata_valid, rd_data_valid;
   logic [CP*DW-1:0]      dfi_wrdata, dfi_rddata, rd_data;
   logic [CP*MW-1:0]      dfi_wrdata_mask;
   logic [$clog2(RO):0]   rd_outstanding;
   logic                  err_rd_unexpected;

   dfi_data_timing #(
      .C_PHASES(CP), .C_DATA_WIDTH(DW), .C_BURST_PHASES(BP),
      .C_LAT_WIDTH(LW), .C_WR_DEPTH(WD), .C_RD_OUTSTANDING(RO)
   ) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_write(cmd_write), .cmd_phase(cmd_phase),
      .cfg_tphy_wrlat(cfg_tphy_wrlat), .cfg_trddata_en(cfg_trddata_en),
      .wr_data(wr_data), .wr_mask(wr_mask), .wr_ready(wr_ready),
      .dfi_wrdata_en(dfi_wrdata_en), .dfi_wrdata(dfi_wrdata),
      .dfi_wrdata_mask(dfi_wrdata_mask), .dfi_rddata_en(dfi_rddata_en),
      .dfi_rddata(dfi_rddata), .dfi_rddata_valid(dfi_rddata_valid),
      .rd_data(rd_data), .rd_data_valid(rd_data_valid),
      .rd_outstanding(rd_outstanding), .err_rd_unexpected(err_rd_unexpected)
   );

   always #5 clk = ~clk;

   typedef struct {
      int               e;
      logic [BP*DW-1:0] d;
      logic [BP*MW-1:0] m;
   } wb_t;

   wb_t  wq[$];
   int   rq[$];
   int   m_out, m_cnt;
   bit   m_err;
   logic [CP*DW-1:0] prev_rd;
   logic [CP-1:0]    prev_rv;
   int   cyc, n_chk, n_err;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
      end
   endtask

   // Expected lanes for cycle c: phase p = c*CP+q is inside a window [e, e+BP).
   task automatic exp_out(input int c, output logic [CP-1:0] wen, output logic [CP*DW-1:0] wd,
                          output logic [CP*MW-1:0] wm, output logic [CP-1:0] ren);
      wen = '0; wd = '0; wm = '0; ren = '0;
      for (int q = 0; q < CP; q++) begin
         int p;
         p = c * CP + q;
         foreach (wq[i]) begin
            if (p >= wq[i].e && p < wq[i].e + BP) begin
               int k;
               logic [BP*DW-1:0] td;
               logic [BP*MW-1:0] tm;
               k  = p - wq[i].e;
               td = wq[i].d;
               tm = wq[i].m;
               wen[q] = 1'b1;
               wd[q*DW +: DW] = td[k*DW +: DW];
               wm[q*MW +: MW] = tm[k*MW +: MW];
            end
         end
         foreach (rq[i]) if (p >= rq[i] && p < rq[i] + BP) ren[q] = 1'b1;
      end
   endtask

   function automatic bit exp_ready(input int c, input bit w, input int ph, input int wl, input int rl);
      int e, n;
      n = 0;
      if (w) begin
         e = c * CP + ph + wl + CP;
         foreach (wq[i]) begin
            if (wq[i].e < e + BP && e < wq[i].e + BP) return 1'b0;
            if ((wq[i].e + BP - 1) / CP >= c) n++;
         end
         return n < WD;
      end
      e = c * CP + ph + rl + CP;
      foreach (rq[i]) if (rq[i] < e + BP && e < rq[i] + BP) return 1'b0;
      return m_out < RO;
   endfunction

   initial begin
      logic [CP-1:0]    xwen, xren;
      logic [CP*DW-1:0] xwd;
      logic [CP*MW-1:0] xwm;
      bit er, acc;
      int pop, dec;

      n_chk = 0; n_err = 0; cyc = 0;
      m_out = 0; m_cnt = 0; m_err = 0; prev_rd = '0; prev_rv = '0;
      rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_phase = '0;
      cfg_tphy_wrlat = '0; cfg_trddata_en = '0; wr_data = '0; wr_mask = '0;
      dfi_rddata = '0; dfi_rddata_valid = '0;
      repeat (3) @(posedge clk);

      for (int n = 0; n < NCYC; n++) begin
         @(posedge clk);
         #1;
         rst       = (cyc > 0) && ($urandom_range(0, 249) == 0);
         cmd_valid = ($urandom_range(0, 1) == 1);
         cmd_write = ($urandom_range(0, 1) == 1);
         cmd_phase = 1'($urandom_range(0, CP - 1));
         cfg_tphy_wrlat = ($urandom_range(0, 9) < 7) ? LW'($urandom_range(0, 3)) : LW'($urandom_range(0, 31));
         cfg_trddata_en = ($urandom_range(0, 9) < 7) ? LW'($urandom_range(0, 3)) : LW'($urandom_range(0, 31));
         for (int i = 0; i < BP * DW / 32; i++) wr_data[i*32 +: 32] = $urandom();
         for (int i = 0; i < BP * MW / 32; i++) wr_mask[i*32 +: 32] = $urandom();
         for (int i = 0; i < CP * DW / 32; i++) dfi_rddata[i*32 +: 32] = $urandom();
         if (m_out > 0 && $urandom_range(0, 2) == 0)  dfi_rddata_valid = CP'($urandom_range(1, 3));
         else if ($urandom_range(0, 59) == 0)         dfi_rddata_valid = CP'($urandom_range(1, 3));
         else                                         dfi_rddata_valid = '0;

         @(negedge clk);
         exp_out(cyc, xwen, xwd, xwm, xren);
         chk("wrdata_en", 512'(dfi_wrdata_en), 512'(xwen));
         chk("wrdata", 512'(dfi_wrdata), 512'(xwd));
         chk("wrdata_mask", 512'(dfi_wrdata_mask), 512'(xwm));
         chk("rddata_en", 512'(dfi_rddata_en), 512'(xren));
         er = exp_ready(cyc, cmd_write, int'(cmd_phase), int'(cfg_tphy_wrlat), int'(cfg_trddata_en));
         chk("cmd_ready", 512'(cmd_ready), 512'(er));
         chk("wr_ready", 512'(wr_ready), 512'(cmd_valid & cmd_write & er));
         chk("rd_outstanding", 512'(rd_outstanding), 512'(m_out));
         chk("err_unexp", 512'(err_rd_unexpected), 512'(m_err));
         chk("rd_data", 512'(rd_data), 512'(prev_rd));
         chk("rd_data_valid", 512'(rd_data_valid), 512'(prev_rv));

         if (rst) begin
            wq.delete(); rq.delete();
            m_out = 0; m_cnt = 0; m_err = 0; prev_rd = '0; prev_rv = '0;
         end else begin
            prev_rd = dfi_rddata;
            prev_rv = dfi_rddata_valid;
            acc = cmd_valid && er;
            pop = $countones(dfi_rddata_valid);
            dec = 0;
            if (pop > 0 && m_out == 0 && m_cnt == 0) m_err = 1'b1;
            else begin
               m_cnt += pop;
               if (m_cnt >= BP) begin
                  m_cnt -= BP;
                  if (m_out > 0) dec = 1;
               end
            end
            m_out = m_out + ((acc && !cmd_write) ? 1 : 0) - dec;
            if (acc && cmd_write) begin
               wb_t b;
               b.e = cyc * CP + int'(cmd_phase) + int'(cfg_tphy_wrlat) + CP;
               b.d = wr_data;
               b.m = wr_mask;
               wq.push_back(b);
            end
            if (acc && !cmd_write)
               rq.push_back(cyc * CP + int'(cmd_phase) + int'(cfg_trddata_en) + CP);
            for (int i = wq.size() - 1; i >= 0; i--)
               if ((wq[i].e + BP - 1) / CP < cyc - 2) wq.delete(i);
            for (int i = rq.size() - 1; i >= 0; i--)
               if ((rq[i] + BP - 1) / CP < cyc - 2) rq.delete(i);
         end
         cyc++;
      end
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
